frame_awb: RTL and testbench

Per-channel RGB gain stage with saturation, manual or automatic (gray-world) white balance, for the pixel path between the capture front end and downstream frame processing. Manual mode applies host gains latched at frame start. Auto mode accumulates per-channel sums over each frame, computes red/blue gains with a sequential divider during blanking, and applies them from the next frame.

---
 rtl/frame_awb.sv | 249 ++++++++++++++++++++++++
 tb/tb_frame_awb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_awb.sv
// Per-channel RGB gain stage with saturation and gray-world auto white balance.
// Frame statistics feed a sequential restoring divider that runs during blanking.
`timescale 1ns/1ps
module frame_awb #(
    parameter int P_DW        = 8,
    parameter int P_GAIN_FRAC = 8,
    parameter int P_GAIN_W    = 10,
    parameter int P_ACC_W     = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [P_DW-1:0]     i_color_r,
    input  logic [P_DW-1:0]     i_color_g,
    input  logic [P_DW-1:0]     i_color_b,
    input  logic                i_pix_valid,
    input  logic                i_start_frame_flag,
    input  logic                i_end_frame_flag,
    input  logic                i_auto_en,
    input  logic [P_GAIN_W-1:0] i_gain_r,
    input  logic [P_GAIN_W-1:0] i_gain_g,
    input  logic [P_GAIN_W-1:0] i_gain_b,
    output logic [P_DW-1:0]     o_color_r,
    output logic [P_DW-1:0]     o_color_g,
    output logic [P_DW-1:0]     o_color_b,
    output logic                o_pix_valid,
    output logic [P_GAIN_W-1:0] o_gain_r,
    output logic [P_GAIN_W-1:0] o_gain_g,
    output logic [P_GAIN_W-1:0] o_gain_b,
    output logic                o_busy,
    output logic                o_stat_drop
);
    localparam int NUM_W  = P_ACC_W + P_GAIN_FRAC;
    localparam int PROD_W = P_DW + P_GAIN_W;
    localparam int CNT_W  = $clog2(NUM_W);

    localparam logic [P_GAIN_W-1:0] UNITY    = P_GAIN_W'(1 << P_GAIN_FRAC);
    localparam logic [PROD_W:0]     ROUND    = (PROD_W+1)'(1 << (P_GAIN_FRAC-1));
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(NUM_W-1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DIV_R = 2'd1;
    localparam logic [1:0] S_DIV_B = 2'd2;
    localparam logic [1:0] S_UPD   = 2'd3;

    function automatic logic [P_ACC_W-1:0] sat_add(input logic [P_ACC_W-1:0] acc,
                                                   input logic [P_DW-1:0]    pix);
        logic [P_ACC_W:0] sum;
        sum = {1'b0, acc} + (P_ACC_W+1)'(pix);
        return sum[P_ACC_W] ? '1 : sum[P_ACC_W-1:0];
    endfunction

    function automatic logic [P_GAIN_W-1:0] clamp_gain(input logic [NUM_W-1:0] quo);
        return (|quo[NUM_W-1:P_GAIN_W]) ? '1 : quo[P_GAIN_W-1:0];
    endfunction

    logic [P_DW-1:0]     pix_in [3];
    logic [P_DW-1:0]     pix_out[3];
    logic [P_GAIN_W-1:0] gain_q [3], gain_d [3];
    logic [P_ACC_W-1:0]  acc_q  [3], acc_d  [3];

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_W-1:0]    num_q, num_d;
    logic [P_ACC_W-1:0]  rem_q, rem_d;
    logic [P_ACC_W-1:0]  den_q, den_d;
    logic [P_ACC_W-1:0]  snap_g_q, snap_g_d, snap_b_q, snap_b_d;
    logic [P_GAIN_W-1:0] res_r_q, res_r_d;
    logic [P_GAIN_W-1:0] pend_r_q, pend_r_d, pend_b_q, pend_b_d;
    logic                auto_q, auto_d;
    logic                in_frame_q, in_frame_d;
    logic                drop_q, drop_d;
    logic                valid1_q, valid2_q;

    assign pix_in[0] = i_color_r;
    assign pix_in[1] = i_color_g;
    assign pix_in[2] = i_color_b;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    logic [P_ACC_W:0] rem_sh, diff;
    logic             fits;
    logic [NUM_W-1:0] quo_nx;
    always_comb begin
        rem_sh = {rem_q, num_q[NUM_W-1]};
        diff   = rem_sh - {1'b0, den_q};
        fits   = rem_sh[P_ACC_W] | ~diff[P_ACC_W];
        quo_nx = {num_q[NUM_W-2:0], fits};
    end

    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        num_d      = num_q;
        rem_d      = rem_q;
        den_d      = den_q;
        snap_g_d   = snap_g_q;
        snap_b_d   = snap_b_q;
        res_r_d    = res_r_q;
        pend_r_d   = pend_r_q;
        pend_b_d   = pend_b_q;
        auto_d     = auto_q;
        in_frame_d = in_frame_q;
        drop_d     = 1'b0;
        acc_d      = acc_q;
        gain_d     = gain_q;

        case (state_q)
            S_DIV_R, S_DIV_B: begin
                num_d = quo_nx;
                rem_d = fits ? diff[P_ACC_W-1:0] : rem_sh[P_ACC_W-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (state_q == S_DIV_R) begin
                        res_r_d = (den_q == '0) ? pend_r_q : clamp_gain(quo_nx);
                        num_d   = {snap_g_q, {P_GAIN_FRAC{1'b0}}};
                        den_d   = snap_b_q;
                        rem_d   = '0;
                        state_d = S_DIV_B;
                    end else begin
                        state_d = S_UPD;
                    end
                end
            end
            S_UPD: begin
                pend_r_d = res_r_q;
                pend_b_d = (den_q == '0) ? pend_b_q : clamp_gain(num_q);
                state_d  = S_IDLE;
            end
            default: ;
        endcase

        // End flag is handled before start so a coincident start sees a fresh frame.
        if (i_end_frame_flag) begin
            in_frame_d = 1'b0;
            for (int c = 0; c < 3; c++) acc_d[c] = '0;
            if (auto_q) begin
                if (state_q == S_IDLE) begin
                    num_d    = {acc_q[1], {P_GAIN_FRAC{1'b0}}};
                    den_d    = acc_q[0];
                    rem_d    = '0;
                    cnt_d    = '0;
                    snap_g_d = acc_q[1];
                    snap_b_d = acc_q[2];
                    state_d  = S_DIV_R;
                end else begin
                    drop_d = 1'b1;
                end
            end
        end

        if (i_start_frame_flag) begin
            in_frame_d = 1'b1;
            auto_d     = i_auto_en;
            for (int c = 0; c < 3; c++) acc_d[c] = i_pix_valid ? P_ACC_W'(pix_in[c]) : '0;
            if (i_auto_en) begin
                gain_d[0] = pend_r_d;
                gain_d[1] = UNITY;
                gain_d[2] = pend_b_d;
            end else begin
                gain_d[0] = i_gain_r;
                gain_d[1] = i_gain_g;
                gain_d[2] = i_gain_b;
            end
        end else if (in_frame_q && !i_end_frame_flag && i_pix_valid) begin
            for (int c = 0; c < 3; c++) acc_d[c] = sat_add(acc_q[c], pix_in[c]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            num_q      <= '0;
            rem_q      <= '0;
            den_q      <= '0;
            snap_g_q   <= '0;
            snap_b_q   <= '0;
            res_r_q    <= UNITY;
            pend_r_q   <= UNITY;
            pend_b_q   <= UNITY;
            auto_q     <= 1'b0;
            in_frame_q <= 1'b0;
            drop_q     <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                gain_q[c] <= UNITY;
                acc_q[c]  <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            num_q      <= num_d;
            rem_q      <= rem_d;
            den_q      <= den_d;
            snap_g_q   <= snap_g_d;
            snap_b_q   <= snap_b_d;
            res_r_q    <= res_r_d;
            pend_r_q   <= pend_r_d;
            pend_b_q   <= pend_b_d;
            auto_q     <= auto_d;
            in_frame_q <= in_frame_d;
            drop_q     <= drop_d;
            gain_q     <= gain_d;
            acc_q      <= acc_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
        end else begin
            valid1_q <= i_pix_valid;
            valid2_q <= valid1_q;
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_chan
        logic [PROD_W-1:0] prod_q;
        logic [P_DW-1:0]   color_q;
        logic [PROD_W:0]   rnd;

        // Rounded quotient sits at bit P_GAIN_FRAC upward; any bit above the pixel width saturates.
        assign rnd = {1'b0, prod_q} + ROUND;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                prod_q  <= '0;
                color_q <= '0;
            end else begin
                prod_q  <= PROD_W'(pix_in[c]) * PROD_W'(gain_q[c]);
                color_q <= (|rnd[PROD_W:P_GAIN_FRAC+P_DW]) ? '1
                                                          : rnd[P_GAIN_FRAC+P_DW-1:P_GAIN_FRAC];
            end
        end
        assign pix_out[c] = color_q;
    end

    assign o_color_r   = pix_out[0];
    assign o_color_g   = pix_out[1];
    assign o_color_b   = pix_out[2];
    assign o_pix_valid = valid2_q;
    assign o_gain_r    = gain_q[0];
    assign o_gain_g    = gain_q[1];
    assign o_gain_b    = gain_q[2];
    assign o_busy      = (state_q != S_IDLE);
    assign o_stat_drop = drop_q;
endmodule

// File: tb/tb_frame_awb.sv
// Directed bench for frame_awb: manual gains, gray-world auto update, clamp,
// statistics drop, mid-frame stability and reset during a divide.
`timescale 1ns/1ps
module tb_frame_awb;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_color_r, i_color_g, i_color_b;
    logic       i_pix_valid, i_start, i_end, i_auto_en;
    logic [9:0] i_gain_r, i_gain_g, i_gain_b;
    logic [7:0] o_color_r, o_color_g, o_color_b;
    logic       o_pix_valid, o_busy, o_stat_drop;
    logic [9:0] o_gain_r, o_gain_g, o_gain_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    frame_awb dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_color_r          (i_color_r),
        .i_color_g          (i_color_g),
        .i_color_b          (i_color_b),
        .i_pix_valid        (i_pix_valid),
        .i_start_frame_flag (i_start),
        .i_end_frame_flag   (i_end),
        .i_auto_en          (i_auto_en),
        .i_gain_r           (i_gain_r),
        .i_gain_g           (i_gain_g),
        .i_gain_b           (i_gain_b),
        .o_color_r          (o_color_r),
        .o_color_g          (o_color_g),
        .o_color_b          (o_color_b),
        .o_pix_valid        (o_pix_valid),
        .o_gain_r           (o_gain_r),
        .o_gain_g           (o_gain_g),
        .o_gain_b           (o_gain_b),
        .o_busy             (o_busy),
        .o_stat_drop        (o_stat_drop)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int r, input int g, input int b, input bit v);
        i_color_r   = 8'(r);
        i_color_g   = 8'(g);
        i_color_b   = 8'(b);
        i_pix_valid = v;
    endtask

    task automatic pulse_start(input bit auto_en);
        i_auto_en = auto_en;
        i_start   = 1'b1;
        step();
        i_start   = 1'b0;
    endtask

    task automatic pulse_end();
        i_end = 1'b1;
        step();
        i_end = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (o_busy && n < 300) begin
            n++;
            step();
        end
    endtask

    int n;
    int drops;
    bit busy_after;

    initial begin
        rst = 1'b1;
        i_start = 1'b0; i_end = 1'b0; i_auto_en = 1'b0;
        i_gain_r = 10'd256; i_gain_g = 10'd256; i_gain_b = 10'd256;
        pix(0, 0, 0, 1'b0);
        step();
        step();
        check("rst_color_r", o_color_r, 0);
        check("rst_valid", o_pix_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_drop", o_stat_drop, 0);
        check("rst_gain_r", o_gain_r, 256);
        check("rst_gain_g", o_gain_g, 256);
        check("rst_gain_b", o_gain_b, 256);
        rst = 1'b0;
        step();

        // Manual mode: gain_r 384 -> 150, saturate 255, round 2
        i_gain_r = 10'd384;
        pulse_start(1'b0);
        check("man_gain_r", o_gain_r, 384);
        pix(100, 100, 100, 1'b1); step();
        pix(200, 100, 100, 1'b1); step();
        check("man_valid", o_pix_valid, 1);
        check("man_r100", o_color_r, 150);
        check("man_g100", o_color_g, 100);
        pix(1, 100, 100, 1'b1); step();
        check("man_r200_sat", o_color_r, 255);
        pix(0, 0, 0, 1'b0); step();
        check("man_r1_round", o_color_r, 2);
        step();
        check("man_valid_low", o_pix_valid, 0);

        // Mid-frame manual gain change must not take effect
        i_gain_r = 10'd512;
        step();
        step();
        check("mid_gain_r", o_gain_r, 384);
        pulse_end();
        check("man_no_busy", o_busy, 0);

        // Auto mode: R=50 G=100 B=200 x4 -> gains r=512 b=128
        pulse_start(1'b1);
        check("auto_first_gain_r", o_gain_r, 256);
        repeat (4) begin
            pix(50, 100, 200, 1'b1); step();
        end
        pix(0, 0, 0, 1'b0);
        pulse_end();
        check("auto_busy_start", o_busy, 1);
        wait_idle(n);
        check("auto_busy_len", n, 81);
        pulse_start(1'b1);
        check("auto_gain_r", o_gain_r, 512);
        check("auto_gain_g", o_gain_g, 256);
        check("auto_gain_b", o_gain_b, 128);
        pix(50, 100, 200, 1'b1); step();
        pix(0, 0, 0, 1'b0); step();
        check("auto_out_r", o_color_r, 100);
        check("auto_out_g", o_color_g, 100);
        check("auto_out_b", o_color_b, 100);

        // Drop: second end flag 20 cycles after the first
        repeat (3) begin
            pix(50, 100, 200, 1'b1); step();
        end
        pix(0, 0, 0, 1'b0);
        pulse_end();
        repeat (20) step();
        pulse_end();
        drops = 0;
        n = 0;
        while (o_busy && n < 300) begin
            drops += int'(o_stat_drop);
            n++;
            step();
        end
        check("drop_remaining_busy", n, 60);
        busy_after = 1'b0;
        repeat (5) begin
            drops += int'(o_stat_drop);
            busy_after |= o_busy;
            step();
        end
        check("drop_pulses", drops, 1);
        check("drop_no_second_div", busy_after, 0);
        pulse_start(1'b1);
        check("drop_gain_r", o_gain_r, 512);
        check("drop_gain_b", o_gain_b, 128);

        // Reset 30 cycles into DIV_R aborts the divide
        pix(50, 100, 200, 1'b1); step();
        pix(0, 0, 0, 1'b0);
        pulse_end();
        repeat (30) step();
        check("mid_div_busy", o_busy, 1);
        rst = 1'b1;
        #1;
        check("rst_div_busy", o_busy, 0);
        check("rst_div_gain_r", o_gain_r, 256);
        check("rst_div_gain_g", o_gain_g, 256);
        check("rst_div_gain_b", o_gain_b, 256);
        step();
        rst = 1'b0;
        step();
        pulse_start(1'b1);
        check("post_rst_gain_r", o_gain_r, 256);
        check("post_rst_gain_b", o_gain_b, 256);

        // Clamp and zero denominator: R=1 G=255 B=0
        pix(1, 255, 0, 1'b1); step();
        pix(0, 0, 0, 1'b0);
        pulse_end();
        wait_idle(n);
        check("clamp_busy_len", n, 81);
        pulse_start(1'b1);
        check("clamp_gain_r", o_gain_r, 1023);
        check("clamp_gain_g", o_gain_g, 256);
        check("zero_den_gain_b", o_gain_b, 256);
        pix(1, 0, 0, 1'b1); step();
        pix(0, 0, 0, 1'b0); step();
        check("clamp_out_r", o_color_r, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
